// File: rtl/bcd_conv_arbiter.sv
// Two-requester round-robin front end for a shared iterative subtract-by-ten
// binary-to-decimal converter; each requester keeps its own held digit registers.
module bcd_conv_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] bin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done0,
  output logic             done1,
  output logic [3:0]       tens0,
  output logic [3:0]       ones0,
  output logic [3:0]       tens1,
  output logic [3:0]       ones1
);

  typedef enum logic {S_IDLE, S_SUB} state_t;

  localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [3:0]       r_cnt;
  logic             r_owner;
  logic             r_last;
  logic             r_gnt0, r_gnt1, r_busy, r_done0, r_done1;
  logic [3:0]       r_tens0, r_ones0, r_tens1, r_ones1;
  logic             w_win;

  // On a tie the requester not granted last wins; r_last resets to 1 so req0 wins first.
  assign w_win = (req0 && req1) ? ~r_last : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_busy  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_tens0 <= '0;
      r_ones0 <= '0;
      r_tens1 <= '0;
      r_ones1 <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_rem   <= w_win ? bin1 : bin0;
            r_cnt   <= '0;
            r_owner <= w_win;
            r_last  <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_busy  <= 1'b1;
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          if (r_rem >= TEN) begin
            r_rem <= r_rem - TEN;
            r_cnt <= r_cnt + 4'd1;
          end else begin
            if (r_owner) begin
              r_tens1 <= r_cnt;
              r_ones1 <= r_rem[3:0];
              r_done1 <= 1'b1;
            end else begin
              r_tens0 <= r_cnt;
              r_ones0 <= r_rem[3:0];
              r_done0 <= 1'b1;
            end
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign busy  = r_busy;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign tens0 = r_tens0;
  assign ones0 = r_ones0;
  assign tens1 = r_tens1;
  assign ones1 = r_ones1;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Randomized self-checking bench for bcd_conv_arbiter against a divide/modulo
// reference model with round-robin tie tracking.
module tb_bcd_conv_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [5:0] bin0 = '0, bin1 = '0;
  logic       gnt0, gnt1, busy, done0, done1;
  logic [3:0] tens0, ones0, tens1, ones1;

  int npass = 0;
  int ntotal = 0;

  // Reference digits currently expected on each requester's outputs.
  int exp_tens [2];
  int exp_ones [2];

  bcd_conv_arbiter #(.WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done0(done0), .done1(done1),
    .tens0(tens0), .ones0(ones0), .tens1(tens1), .ones1(ones1)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] all_outs();
    return {gnt0, gnt1, busy, done0, done1, tens0, ones0, tens1, ones1};
  endfunction

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_tens[0] = 0; exp_ones[0] = 0; exp_tens[1] = 0; exp_ones[1] = 0;
  endtask

  // Stimulus driver only: raises one request, drops it after its grant, and
  // reports the edge numbers (request at edge 0) plus side observations.
  task automatic run_conv(input bit who, input logic [5:0] v,
                          output int g_edge, output int d_edge,
                          output bit other_done, output bit busy_g, output bit busy_d);
    g_edge = -1; d_edge = -1; other_done = 1'b0; busy_g = 1'b0; busy_d = 1'b1;
    if (who) begin bin1 = v; req1 = 1'b1; end
    else     begin bin0 = v; req0 = 1'b1; end
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (who ? done0 : done1) other_done = 1'b1;
      if (g_edge < 0 && (who ? gnt1 : gnt0)) begin
        g_edge = e; busy_g = busy;
        if (who) req1 = 1'b0; else req0 = 1'b0;
      end
      if (who ? done1 : done0) begin d_edge = e; busy_d = busy; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    ntotal++;
    if (all_outs() !== 21'd0) $display("FAIL reset_during: outs=%h want 0", all_outs());
    else npass++;
    do_reset();
    @(posedge clk); #1;
    ntotal++;
    if (all_outs() !== 21'd0) $display("FAIL reset_after: outs=%h want 0", all_outs());
    else npass++;
  endtask

  task automatic test_first_zero();
    int g, d; bit od, bg, bd;
    run_conv(1'b0, 6'd0, g, d, od, bg, bd);
    ntotal++;
    if (g !== 1 || d !== 2) $display("FAIL zero_latency: gnt=%0d done=%0d want 1 2", g, d);
    else npass++;
    ntotal++;
    if (tens0 !== 4'd0 || ones0 !== 4'd0 || busy !== 1'b0 || bg !== 1'b1)
      $display("FAIL zero_result: t=%0d o=%0d busy=%b busy_at_gnt=%b want 0 0 0 1", tens0, ones0, busy, bg);
    else npass++;
  endtask

  task automatic test_max();
    int g, d; bit od, bg, bd;
    logic [3:0] t0, o0;
    run_conv(1'b0, 6'd38, g, d, od, bg, bd);
    t0 = tens0; o0 = ones0;
    run_conv(1'b1, 6'd63, g, d, od, bg, bd);
    ntotal++;
    if (g !== 1 || d !== 8) $display("FAIL max_latency: gnt=%0d done=%0d want 1 8", g, d);
    else npass++;
    ntotal++;
    if (tens1 !== 4'd6 || ones1 !== 4'd3) $display("FAIL max_digits: t=%0d o=%0d want 6 3", tens1, ones1);
    else npass++;
    ntotal++;
    if (tens0 !== t0 || ones0 !== o0 || t0 !== 4'd3 || o0 !== 4'd8 || od)
      $display("FAIL max_other: t0=%0d o0=%0d done0=%b want 3 8 0", tens0, ones0, od);
    else npass++;
    exp_tens[0] = 3; exp_ones[0] = 8; exp_tens[1] = 6; exp_ones[1] = 3;
  endtask

  task automatic test_tie();
    int g0 = -1, g1 = -1, d0 = -1, d1 = -1;
    do_reset();
    @(posedge clk); #1;
    bin0 = 6'd25; bin1 = 6'd10; req0 = 1'b1; req1 = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (gnt0 && g0 < 0) begin g0 = e; req0 = 1'b0; end
      if (gnt1 && g1 < 0) begin g1 = e; req1 = 1'b0; end
      if (done0 && d0 < 0) d0 = e;
      if (done1 && d1 < 0) begin d1 = e; break; end
    end
    req0 = 1'b0; req1 = 1'b0;
    ntotal++;
    if (g0 !== 1 || d0 !== 4) $display("FAIL tie_first: gnt0=%0d done0=%0d want 1 4", g0, d0);
    else npass++;
    ntotal++;
    if (g1 !== d0 + 1 || d1 !== 7) $display("FAIL tie_second: gnt1=%0d done1=%0d want 5 7", g1, d1);
    else npass++;
    ntotal++;
    if (tens0 !== 4'd2 || ones0 !== 4'd5 || tens1 !== 4'd1 || ones1 !== 4'd0)
      $display("FAIL tie_digits: %0d%0d %0d%0d want 25 10", tens0, ones0, tens1, ones1);
    else npass++;
  endtask

  task automatic test_alternate();
    int grants[$];
    int dones = 0;
    int last = 1;
    int want;
    int cur_bin [2];
    do_reset();
    @(posedge clk); #1;
    cur_bin[0] = $urandom_range(0, 63); cur_bin[1] = $urandom_range(0, 63);
    bin0 = 6'(cur_bin[0]); bin1 = 6'(cur_bin[1]); req0 = 1'b1; req1 = 1'b1;
    for (int e = 1; e <= 100 && dones < 4; e++) begin
      @(posedge clk); #1;
      if (gnt0) begin grants.push_back(0); req0 = 1'b0; end
      if (gnt1) begin grants.push_back(1); req1 = 1'b0; end
      if (done0 || done1) begin
        dones++;
        ntotal++;
        if (done0 ? (tens0 !== 4'(cur_bin[0] / 10) || ones0 !== 4'(cur_bin[0] % 10))
                  : (tens1 !== 4'(cur_bin[1] / 10) || ones1 !== 4'(cur_bin[1] % 10)))
          $display("FAIL alt_digits: done0=%b got %0d%0d/%0d%0d bins %0d %0d",
                   done0, tens0, ones0, tens1, ones1, cur_bin[0], cur_bin[1]);
        else npass++;
        if (!req0) begin cur_bin[0] = $urandom_range(0, 63); bin0 = 6'(cur_bin[0]); req0 = 1'b1; end
        if (!req1) begin cur_bin[1] = $urandom_range(0, 63); bin1 = 6'(cur_bin[1]); req1 = 1'b1; end
        if (dones == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    ntotal++;
    if (grants.size() != 4) $display("FAIL alt_count: grants=%0d want 4", grants.size());
    else npass++;
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      want = 1 - last; last = want;
      ntotal++;
      if (grants[i] != want) $display("FAIL alt_order[%0d]: got %0d want %0d", i, grants[i], want);
      else npass++;
    end
    @(posedge clk); #1;
    exp_tens[0] = cur_bin[0] / 10; exp_ones[0] = cur_bin[0] % 10;
    exp_tens[1] = cur_bin[1] / 10; exp_ones[1] = cur_bin[1] % 10;
  endtask

  task automatic test_boundary();
    int vals[6] = '{9, 10, 19, 20, 59, 60};
    int g, d; bit od, bg, bd;
    bit who;
    for (int i = 0; i < 6; i++) begin
      who = 1'(i);
      run_conv(who, 6'(vals[i]), g, d, od, bg, bd);
      exp_tens[who] = vals[i] / 10; exp_ones[who] = vals[i] % 10;
      ntotal++;
      if ((who ? tens1 : tens0) !== 4'(exp_tens[who]) || (who ? ones1 : ones0) !== 4'(exp_ones[who])
          || d !== vals[i] / 10 + 2)
        $display("FAIL boundary_%0d: got %0d%0d done_edge=%0d want %0d%0d edge %0d", vals[i],
                 who ? tens1 : tens0, who ? ones1 : ones0, d, exp_tens[who], exp_ones[who], vals[i] / 10 + 2);
      else npass++;
    end
  endtask

  task automatic test_random();
    int g, d; bit od, bg, bd;
    bit who;
    int v;
    for (int i = 0; i < 16; i++) begin
      who = 1'($urandom_range(0, 1));
      v = $urandom_range(0, 63);
      run_conv(who, 6'(v), g, d, od, bg, bd);
      exp_tens[who] = v / 10; exp_ones[who] = v % 10;
      ntotal++;
      if (tens0 !== 4'(exp_tens[0]) || ones0 !== 4'(exp_ones[0]) ||
          tens1 !== 4'(exp_tens[1]) || ones1 !== 4'(exp_ones[1]))
        $display("FAIL rand_digits[%0d]: got %0d%0d %0d%0d want %0d%0d %0d%0d (req%0d=%0d)", i,
                 tens0, ones0, tens1, ones1, exp_tens[0], exp_ones[0], exp_tens[1], exp_ones[1], who, v);
      else npass++;
      ntotal++;
      if (g !== 1 || d !== v / 10 + 2 || od || bd !== 1'b0)
        $display("FAIL rand_timing[%0d]: gnt=%0d done=%0d other=%b busy=%b want 1 %0d 0 0",
                 i, g, d, od, bd, v / 10 + 2);
      else npass++;
    end
  endtask

  task automatic test_reset_mid();
    int g, d; bit od, bg, bd;
    bit seen_done = 1'b0;
    bin0 = 6'd47; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    ntotal++;
    if (all_outs() !== 21'd0) $display("FAIL reset_mid_outs: outs=%h want 0", all_outs());
    else npass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done0 || done1 || busy) seen_done = 1'b1;
    end
    ntotal++;
    if (seen_done) $display("FAIL reset_mid_nodone: activity after abandoned conversion, want none");
    else npass++;
    run_conv(1'b0, 6'd47, g, d, od, bg, bd);
    ntotal++;
    if (tens0 !== 4'd4 || ones0 !== 4'd7 || d !== 6 || tens1 !== 4'd0)
      $display("FAIL reset_mid_fresh: got %0d%0d edge=%0d tens1=%0d want 47 edge 6 tens1 0",
               tens0, ones0, d, tens1);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_first_zero();
    test_max();
    test_tie();
    test_alternate();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
